// File: rtl/mult_seq_r4.sv
// Sequential unsigned multiplier: b is consumed two bits per clock (radix-4 shift-add).
// Operand and result sides use valid/ready handshakes; y always reflects the accumulator.
module mult_seq_r4 #(
  parameter int WA = 4,
  parameter int WB = 2,
  localparam int WY = WA + WB
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WA-1:0] a,
  input  logic [WB-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WY-1:0] y,
  output logic          busy
);

  localparam int ND = WB / 2;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;

  generate
    if (WB < 2 || (WB % 2) != 0) begin : g_bad_wb
      $error("mult_seq_r4: WB must be even and >= 2");
    end
  endgenerate

  // Handshake rule: a transfer happens on a rising edge where valid and ready
  // are both high; ready/valid here are registers and never depend on the
  // partner's signal combinationally.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [WA-1:0] a_r;
  logic [WB-1:0] b_r;
  logic [CW-1:0] cnt;
  logic [WY-1:0] acc;
  logic [WA+1:0] pp;
  logic [WY-1:0] pp_sh;
  logic          last;

  // a_r times the current low digit of b_r, aligned to the digit position.
  always_comb begin
    pp    = {2'b00, a_r} * {{WA{1'b0}}, b_r[1:0]};
    pp_sh = WY'(pp) << {cnt, 1'b0};
    last  = (cnt == CW'(ND - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      cnt       <= '0;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= a;
            b_r      <= b;
            acc      <= '0;
            cnt      <= '0;
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          acc <= acc + pp_sh;
          b_r <= b_r >> 2;
          cnt <= cnt + CW'(1);
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign y = acc;

endmodule

// File: tb/tb_mult_seq_r4.sv
// Bench for mult_seq_r4: 8x8 instance checked through a product/latency scoreboard,
// plus a 4x2 instance swept over all operand pairs.
module tb_mult_seq_r4;

  localparam int WA = 8;
  localparam int WB = 8;
  localparam int ND = WB / 2;
  localparam int WY = WA + WB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WA-1:0] a = '0;
  logic [WB-1:0] b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [WY-1:0] y;
  logic          busy;

  logic          l_in_valid = 1'b0;
  logic          l_in_ready;
  logic [3:0]    l_a = '0;
  logic [1:0]    l_b = '0;
  logic          l_out_valid;
  logic          l_out_ready = 1'b1;
  logic [5:0]    l_y;
  logic          l_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_in = 0;
  int n_out = 0;
  bit rand_ready = 1'b0;
  bit man_ready = 1'b1;
  bit prev_ov = 1'b0;
  logic [WY-1:0] exp_q[$];
  int lat_q[$];

  mult_seq_r4 #(.WA(WA), .WB(WB)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
  );

  mult_seq_r4 #(.WA(4), .WB(2)) u_leg (
    .clk(clk), .rst(rst),
    .in_valid(l_in_valid), .in_ready(l_in_ready), .a(l_a), .b(l_b),
    .out_valid(l_out_valid), .out_ready(l_out_ready), .y(l_y), .busy(l_busy)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [WY-1:0] act, input logic [WY-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // consumer side: random or directed out_ready, changed shortly after each edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : man_ready;
    end
  end

  // scoreboard monitor: latency on the out_valid rise, product on the handshake
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !prev_ov) begin
          if (lat_q.size() == 0) chk("unexpected_valid", WY'(1), WY'(0));
          else chk("latency", WY'(cyc - lat_q.pop_front()), WY'(ND));
        end
        if (out_valid && out_ready) begin
          n_out++;
          if (exp_q.size() == 0) chk("extra_result", WY'(1), WY'(0));
          else chk("product", y, exp_q.pop_front());
        end
        chk("in_ready_vs_busy", WY'(in_ready), WY'(!busy));
        prev_ov = out_valid;
      end
    end
  end

  // driver: present operands and hold them until accepted
  task automatic send(input logic [WA-1:0] av, input logic [WB-1:0] bv);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a = av;
    b = bv;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", WY'(0), WY'(1));
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(WY'(av) * WY'(bv));
    lat_q.push_back(cyc + 1);
    n_in++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", WY'(exp_q.size()), WY'(0));
  endtask

  task automatic leg_one(input int ai, input int bi);
    int t = 0;
    @(negedge clk);
    l_in_valid = 1'b1;
    l_a = 4'(ai);
    l_b = 2'(bi);
    while (!l_in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    l_in_valid = 1'b0;
    @(negedge clk);
    chk("leg_valid", WY'(l_out_valid), WY'(1));
    chk("leg_product", WY'(l_y), WY'(ai * bi));
  endtask

  initial begin
    int t;
    rst = 1'b1;
    #12;
    chk("rst_in_ready", WY'(in_ready), WY'(1));
    chk("rst_out_valid", WY'(out_valid), WY'(0));
    chk("rst_busy", WY'(busy), WY'(0));
    chk("rst_y", y, WY'(0));
    chk("rst_leg_in_ready", WY'(l_in_ready), WY'(1));
    @(negedge clk);
    rst = 1'b0;

    // maximum operands
    man_ready = 1'b1;
    send(8'd255, 8'd255);
    chk("busy_after_accept", WY'(busy), WY'(1));
    chk("y_zero_after_accept", y, WY'(0));
    wait_drain();

    // zero operands keep full latency
    send(8'd0, 8'hAB);
    send(8'hAB, 8'd0);
    wait_drain();

    // backpressure: result held, operands during DONE not captured
    man_ready = 1'b0;
    repeat (2) @(negedge clk);
    send(8'd200, 8'd3);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    in_valid = 1'b1;
    a = 8'd7;
    b = 8'd7;
    repeat (5) begin
      @(negedge clk);
      chk("bp_y", y, WY'(600));
      chk("bp_out_valid", WY'(out_valid), WY'(1));
      chk("bp_in_ready", WY'(in_ready), WY'(0));
    end
    in_valid = 1'b0;
    man_ready = 1'b1;
    wait_drain();
    send(8'd7, 8'd7);
    wait_drain();

    // asynchronous reset two compute edges into an operation
    send(8'd99, 8'd77);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", WY'(out_valid), WY'(0));
    chk("mid_rst_in_ready", WY'(in_ready), WY'(1));
    chk("mid_rst_y", y, WY'(0));
    chk("mid_rst_busy", WY'(busy), WY'(0));
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    n_in--;
    @(negedge clk);
    rst = 1'b0;
    send(8'd3, 8'd5);
    wait_drain();

    // random soak with random source gaps and consumer stalls
    rand_ready = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(WA'($urandom), WB'($urandom));
    end
    wait_drain();
    rand_ready = 1'b0;
    man_ready = 1'b1;

    // legacy 4x2 configuration: every operand pair
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 4; bi++)
        leg_one(ai, bi);

    repeat (4) @(negedge clk);
    chk("result_count", WY'(n_out), WY'(n_in));
    chk("queue_empty", WY'(exp_q.size()), WY'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
